md_unit_ctrl: RTL

- Multiply/divide sequencer and HI/LO owner for the 5-stage MIPS pipeline.
- Accepts mult/div/mthi/mtlo issued from the E stage and models the multi-cycle latency with a countdown.
- Drives the D-stage stall request for any HI/LO-using instruction, and commits results to HI/LO.
- Sits beside the ALU, fed by the ID/EX pipeline register outputs (start, op, rs/rt values) and the exception request.

---
 rtl/md_unit_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for the E stage of the 5-stage pipeline.
// Optional stall-cycle counter enabled by defining MD_STALL_CNT_EN.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic [31:0] md_stall_cnt
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r;
  logic [31:0] hi_r, lo_r, pend_hi_r, pend_lo_r;
  logic        pend_wr_r, busy_r, done_r;

  logic        accept_s, load_s, mthi_s, mtlo_s, commit_s;
  logic [3:0]  load_cnt_s;
  logic [31:0] res_hi_s, res_lo_s;
  logic        res_wr_s;

  logic [63:0] prod_s_s, prod_u_s;
  logic [31:0] rs_abs_s, rt_abs_s, num_s, den_s, den_safe_s, uq_s, ur_s;
  logic        is_sdiv_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) state_nxt_s = ST_RUN;
        else        state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == 4'd1) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control decode: accept only in IDLE and only when the E instruction is not flushed
  always_comb begin
    accept_s   = E_start && !req && (state_r == ST_IDLE);
    load_s     = 1'b0;
    mthi_s     = 1'b0;
    mtlo_s     = 1'b0;
    load_cnt_s = 4'(MULT_CYCLES);
    commit_s   = (state_r == ST_RUN) && (cnt_r == 4'd1);
    case (E_md_op)
      OP_MULT, OP_MULTU: begin
        load_s     = accept_s;
        load_cnt_s = 4'(MULT_CYCLES);
      end
      OP_DIV, OP_DIVU: begin
        load_s     = accept_s;
        load_cnt_s = 4'(DIV_CYCLES);
      end
      OP_MTHI: mthi_s = accept_s;
      OP_MTLO: mtlo_s = accept_s;
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Arithmetic: signed product via sign-extended 64-bit multiply, signed divide via magnitudes
  always_comb begin
    prod_s_s   = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
    prod_u_s   = {32'd0, E_rs} * {32'd0, E_rt};
    is_sdiv_s  = (E_md_op == OP_DIV);
    rs_abs_s   = E_rs[31] ? (32'd0 - E_rs) : E_rs;
    rt_abs_s   = E_rt[31] ? (32'd0 - E_rt) : E_rt;
    num_s      = is_sdiv_s ? rs_abs_s : E_rs;
    den_s      = is_sdiv_s ? rt_abs_s : E_rt;
    den_safe_s = (den_s == 32'd0) ? 32'd1 : den_s;
    uq_s       = num_s / den_safe_s;
    ur_s       = num_s % den_safe_s;
    res_hi_s   = 32'd0;
    res_lo_s   = 32'd0;
    res_wr_s   = 1'b1;
    case (E_md_op)
      OP_MULT: begin
        res_hi_s = prod_s_s[63:32];
        res_lo_s = prod_s_s[31:0];
      end
      OP_MULTU: begin
        res_hi_s = prod_u_s[63:32];
        res_lo_s = prod_u_s[31:0];
      end
      OP_DIV: begin
        res_lo_s = (E_rs[31] ^ E_rt[31]) ? (32'd0 - uq_s) : uq_s;
        res_hi_s = E_rs[31] ? (32'd0 - ur_s) : ur_s;
        res_wr_s = (E_rt != 32'd0);
      end
      OP_DIVU: begin
        res_lo_s = uq_s;
        res_hi_s = ur_s;
        res_wr_s = (E_rt != 32'd0);
      end
      default: begin
        res_wr_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, countdown, HI/LO commit and moves
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= 4'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_RUN);
      done_r <= commit_s;
      if (load_s) begin
        pend_hi_r <= res_hi_s;
        pend_lo_r <= res_lo_s;
        pend_wr_r <= res_wr_s;
        cnt_r     <= load_cnt_s;
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r - 4'd1;
        if (commit_s && pend_wr_r) begin
          hi_r <= pend_hi_r;
          lo_r <= pend_lo_r;
        end
      end else if (mthi_s) begin
        hi_r <= E_rs;
      end else if (mtlo_s) begin
        lo_r <= E_rs;
      end
    end
  end

  assign md_stall = D_md_use && (E_start || busy_r);
  assign busy     = busy_r;
  assign done     = done_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Stall-cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (md_stall) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign md_stall_cnt = stall_cnt_r;
`else
  assign md_stall_cnt = 32'd0;
`endif

endmodule
